// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU: selects and forwards operands, traps
// divide/modulo by zero, and holds the issued instruction in a registered output stage.
module alu_issue_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Fast_Clock,
  input  logic                 Reset,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [4:0]           In_Op,
  input  logic [4:0]           In_Rs_Addr,
  input  logic [4:0]           In_Rt_Addr,
  input  logic [WIDTH-1:0]     In_Rs_Data,
  input  logic [WIDTH-1:0]     In_Rt_Data,
  input  logic [WIDTH-1:0]     In_Imm,
  input  logic                 In_Use_Imm,
  input  logic [4:0]           In_Rd_Addr,
  input  logic                 In_Write_En,
  input  logic [WIDTH-1:0]     ALU_Result,
  input  logic                 Out_Ready,
  output logic                 Out_Valid,
  output logic [WIDTH-1:0]     Input_1,
  output logic [WIDTH-1:0]     Input_2,
  output logic [4:0]           ALU_Op,
  output logic [4:0]           Out_Rd_Addr,
  output logic                 Out_Write_En,
  output logic                 Div_Zero,
  input  logic                 Trap_Clear,
  output logic [CNT_WIDTH-1:0] Issue_Count
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_NOP = 5'd17;

  logic [0:0]              state;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] op1_p1;
  logic signed [WIDTH-1:0] op2_p1;
  logic [4:0]              alu_op_p1;
  logic [4:0]              rd_p1;
  logic                    we_p1;
  logic                    div_zero;
  logic [CNT_WIDTH-1:0]    issue_cnt;

  logic                    xfer;
  logic                    fwd_rs_p0;
  logic                    fwd_rt_p0;
  logic signed [WIDTH-1:0] op1_p0;
  logic signed [WIDTH-1:0] op2_p0;
  logic                    trap_p0;

  // The instruction held in the output stage is the only forwarding source; r0 never forwards.
  function automatic logic fwd_hit(input logic vld, input logic we,
                                   input logic [4:0] rd, input logic [4:0] src);
    return vld && we && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic logic is_div_zero(input logic [4:0] op, input logic signed [WIDTH-1:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
  endfunction

  // Stage p0: operand select, forwarding and trap detection
  always_comb begin
    In_Ready  = (state == RUN) && (!vld_p1 || Out_Ready);
    xfer      = In_Valid && In_Ready;
    fwd_rs_p0 = fwd_hit(vld_p1, we_p1, rd_p1, In_Rs_Addr);
    fwd_rt_p0 = fwd_hit(vld_p1, we_p1, rd_p1, In_Rt_Addr) && !In_Use_Imm;
    op1_p0    = fwd_rs_p0 ? ALU_Result : In_Rs_Data;
    if (In_Use_Imm)
      op2_p0 = In_Imm;
    else if (fwd_rt_p0)
      op2_p0 = ALU_Result;
    else
      op2_p0 = In_Rt_Data;
    trap_p0   = is_div_zero(In_Op, op2_p0);
  end

  // Stage p1: registered output driving the ALU
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state     <= RUN;
      vld_p1    <= 1'b0;
      op1_p1    <= '0;
      op2_p1    <= '0;
      alu_op_p1 <= OP_NOP;
      rd_p1     <= 5'd0;
      we_p1     <= 1'b0;
      div_zero  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (xfer) begin
        vld_p1    <= 1'b1;
        op1_p1    <= op1_p0;
        op2_p1    <= op2_p0;
        alu_op_p1 <= trap_p0 ? OP_NOP : In_Op;
        rd_p1     <= In_Rd_Addr;
        we_p1     <= trap_p0 ? 1'b0 : In_Write_En;
        issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      end else if (Out_Ready) begin
        vld_p1    <= 1'b0;
        alu_op_p1 <= OP_NOP;
        we_p1     <= 1'b0;
      end

      case (state)
        RUN: begin
          if (xfer && trap_p0) begin
            state    <= TRAP;
            div_zero <= 1'b1;
          end
        end
        default: begin
          if (Trap_Clear) begin
            state    <= RUN;
            div_zero <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Out_Valid    = vld_p1;
  assign Input_1      = op1_p1;
  assign Input_2      = op2_p1;
  assign ALU_Op       = alu_op_p1;
  assign Out_Rd_Addr  = rd_p1;
  assign Out_Write_En = we_p1;
  assign Div_Zero     = div_zero;
  assign Issue_Count  = issue_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the issue stage.
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int CW    = 16;

  logic              Fast_Clock;
  logic              Reset;
  logic              In_Valid;
  logic              In_Ready;
  logic [4:0]        In_Op;
  logic [4:0]        In_Rs_Addr;
  logic [4:0]        In_Rt_Addr;
  logic [WIDTH-1:0]  In_Rs_Data;
  logic [WIDTH-1:0]  In_Rt_Data;
  logic [WIDTH-1:0]  In_Imm;
  logic              In_Use_Imm;
  logic [4:0]        In_Rd_Addr;
  logic              In_Write_En;
  logic [WIDTH-1:0]  ALU_Result;
  logic              Out_Ready;
  logic              Out_Valid;
  logic [WIDTH-1:0]  Input_1;
  logic [WIDTH-1:0]  Input_2;
  logic [4:0]        ALU_Op;
  logic [4:0]        Out_Rd_Addr;
  logic              Out_Write_En;
  logic              Div_Zero;
  logic              Trap_Clear;
  logic [CW-1:0]     Issue_Count;

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction currently presented to the ALU, plus trap/count state
  logic        m_valid, m_we, m_dz, m_trap;
  logic [31:0] m_in1, m_in2;
  logic [4:0]  m_op, m_rd;
  logic [15:0] m_cnt;
  logic [15:0] saved_cnt;

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
    .Fast_Clock  (Fast_Clock),
    .Reset       (Reset),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Op       (In_Op),
    .In_Rs_Addr  (In_Rs_Addr),
    .In_Rt_Addr  (In_Rt_Addr),
    .In_Rs_Data  (In_Rs_Data),
    .In_Rt_Data  (In_Rt_Data),
    .In_Imm      (In_Imm),
    .In_Use_Imm  (In_Use_Imm),
    .In_Rd_Addr  (In_Rd_Addr),
    .In_Write_En (In_Write_En),
    .ALU_Result  (ALU_Result),
    .Out_Ready   (Out_Ready),
    .Out_Valid   (Out_Valid),
    .Input_1     (Input_1),
    .Input_2     (Input_2),
    .ALU_Op      (ALU_Op),
    .Out_Rd_Addr (Out_Rd_Addr),
    .Out_Write_En(Out_Write_En),
    .Div_Zero    (Div_Zero),
    .Trap_Clear  (Trap_Clear),
    .Issue_Count (Issue_Count)
  );

  initial begin
    Fast_Clock = 1'b0;
    forever #5 Fast_Clock = ~Fast_Clock;
  end

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd3:    return (b == 32'd0) ? 32'd0 : a / b;
      5'd4:    return (b == 32'd0) ? 32'd0 : a % b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      5'd7:    return a ^ b;
      5'd18:   return b;
      default: return 32'd0;
    endcase
  endfunction

  assign ALU_Result = alu_fn(Input_1, Input_2, ALU_Op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic ui, input logic [4:0] rd,
                       input logic we);
    In_Valid    = v;
    In_Op       = op;
    In_Rs_Addr  = rs;
    In_Rt_Addr  = rt;
    In_Rs_Data  = rsd;
    In_Rt_Data  = rtd;
    In_Imm      = imm;
    In_Use_Imm  = ui;
    In_Rd_Addr  = rd;
    In_Write_En = we;
  endtask

  // One clock: predict from the rules, clock the DUT, compare everything.
  task automatic step(input bit do_chk);
    logic        rdy, dz, h1, h2;
    logic [31:0] fwd, a, b;
    logic        n_valid, n_we, n_dz, n_trap;
    logic [31:0] n_in1, n_in2;
    logic [4:0]  n_op, n_rd;
    logic [15:0] n_cnt;
    #1;
    rdy = !m_trap && (!m_valid || Out_Ready);
    if (do_chk) chk("in_ready", 32'(In_Ready), 32'(rdy));
    {n_valid, n_we, n_dz, n_trap, n_in1, n_in2, n_op, n_rd, n_cnt} =
      {m_valid, m_we, m_dz, m_trap, m_in1, m_in2, m_op, m_rd, m_cnt};
    if (Reset) begin
      {n_valid, n_we, n_dz, n_trap} = 4'b0000;
      n_in1 = 32'd0; n_in2 = 32'd0; n_op = 5'd17; n_rd = 5'd0; n_cnt = 16'd0;
    end else begin
      if (In_Valid && rdy) begin
        fwd = alu_fn(m_in1, m_in2, m_op);
        h1  = m_valid && m_we && (m_rd != 5'd0) && (m_rd == In_Rs_Addr);
        h2  = m_valid && m_we && (m_rd != 5'd0) && (m_rd == In_Rt_Addr);
        a   = h1 ? fwd : In_Rs_Data;
        b   = In_Use_Imm ? In_Imm : (h2 ? fwd : In_Rt_Data);
        dz  = ((In_Op == 5'd3) || (In_Op == 5'd4)) && (b == 32'd0);
        n_valid = 1'b1;
        n_in1   = a;
        n_in2   = b;
        n_op    = dz ? 5'd17 : In_Op;
        n_rd    = In_Rd_Addr;
        n_we    = dz ? 1'b0 : In_Write_En;
        n_cnt   = m_cnt + 16'd1;
        if (dz) begin
          n_trap = 1'b1;
          n_dz   = 1'b1;
        end
      end else if (Out_Ready) begin
        n_valid = 1'b0;
        n_op    = 5'd17;
        n_we    = 1'b0;
      end
      if (m_trap && Trap_Clear) begin
        n_trap = 1'b0;
        n_dz   = 1'b0;
      end
    end
    @(posedge Fast_Clock);
    #1;
    {m_valid, m_we, m_dz, m_trap, m_in1, m_in2, m_op, m_rd, m_cnt} =
      {n_valid, n_we, n_dz, n_trap, n_in1, n_in2, n_op, n_rd, n_cnt};
    if (do_chk) begin
      chk("out_valid", 32'(Out_Valid), 32'(m_valid));
      chk("input_1", Input_1, m_in1);
      chk("input_2", Input_2, m_in2);
      chk("alu_op", 32'(ALU_Op), 32'(m_op));
      chk("out_rd", 32'(Out_Rd_Addr), 32'(m_rd));
      chk("out_we", 32'(Out_Write_En), 32'(m_we));
      chk("div_zero", 32'(Div_Zero), 32'(m_dz));
      chk("issue_count", 32'(Issue_Count), 32'(m_cnt));
    end
  endtask

  initial begin
    {m_valid, m_we, m_dz, m_trap} = 4'b0000;
    m_in1 = 32'd0; m_in2 = 32'd0; m_op = 5'd17; m_rd = 5'd0; m_cnt = 16'd0;
    Reset = 1'b1; Out_Ready = 1'b1; Trap_Clear = 1'b0;
    drive(1'b0, 5'd17, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0);
    step(1'b1);
    chk("rst_op_nop", 32'(ALU_Op), 32'd17);
    Reset = 1'b0;

    // Reset during a stall aborts the held instruction
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 1'b1);
    Out_Ready = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("stall_valid", 32'(Out_Valid), 32'd1);
    Reset = 1'b1;
    step(1'b1);
    Reset = 1'b0;
    chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
    chk("mid_rst_op", 32'(ALU_Op), 32'd17);
    chk("mid_rst_cnt", 32'(Issue_Count), 32'd0);
    Out_Ready = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(In_Ready), 32'd1);

    // ADD r1=r2+r3 then SUB r4=r1-r2 with stale Rs data
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 1'b1);
    step(1'b1);
    drive(1'b1, 5'd1, 5'd1, 5'd2, 32'd0, 32'd5, 32'd0, 1'b0, 5'd4, 1'b1);
    step(1'b1);
    chk("fwd_in1", Input_1, 32'd12);
    chk("fwd_in2", Input_2, 32'd5);
    chk("fwd_op", 32'(ALU_Op), 32'd1);

    // Writer of r0 must not forward
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 1'b1);
    step(1'b1);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1);
    step(1'b1);
    chk("r0_in1", Input_1, 32'd0);

    // Producer followed by a bubble is not forwarded
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 5'd9, 1'b1);
    step(1'b1);
    drive(1'b0, 5'd17, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1);
    drive(1'b1, 5'd0, 5'd9, 5'd9, 32'd33, 32'd44, 32'd0, 1'b0, 5'd6, 1'b1);
    step(1'b1);
    chk("bubble_in1", Input_1, 32'd33);
    chk("bubble_in2", Input_2, 32'd44);

    // Downstream stall for three cycles, then release
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 5'd6, 1'b1);
    step(1'b1);
    Out_Ready = 1'b0;
    drive(1'b1, 5'd5, 5'd7, 5'd8, 32'd9, 32'd3, 32'd0, 1'b0, 5'd7, 1'b1);
    saved_cnt = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("stall_ready", 32'(In_Ready), 32'd0);
      chk("stall_in1", Input_1, 32'd1);
    end
    Out_Ready = 1'b1;
    step(1'b1);
    chk("release_cnt", 32'(Issue_Count), 32'(saved_cnt + 16'd1));
    chk("release_in1", Input_1, 32'd9);

    // DIV by a zero immediate traps until Trap_Clear
    drive(1'b1, 5'd3, 5'd2, 5'd3, 32'd8, 32'd4, 32'd0, 1'b1, 5'd7, 1'b1);
    step(1'b1);
    chk("trap_op", 32'(ALU_Op), 32'd17);
    chk("trap_we", 32'(Out_Write_En), 32'd0);
    chk("trap_valid", 32'(Out_Valid), 32'd1);
    chk("trap_flag", 32'(Div_Zero), 32'd1);
    chk("trap_ready", 32'(In_Ready), 32'd0);
    drive(1'b1, 5'd0, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 1'b0, 5'd8, 1'b1);
    step(1'b1);
    step(1'b1);
    chk("trap_hold_ready", 32'(In_Ready), 32'd0);
    chk("trap_hold_flag", 32'(Div_Zero), 32'd1);
    Trap_Clear = 1'b1;
    step(1'b1);
    Trap_Clear = 1'b0;
    chk("clear_flag", 32'(Div_Zero), 32'd0);
    chk("clear_ready", 32'(In_Ready), 32'd1);
    step(1'b1);
    chk("resume_valid", 32'(Out_Valid), 32'd1);

    // Randomized traffic with frequent hazards and divide traps
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      Reset      = ($urandom_range(0, 199) == 0);
      Out_Ready  = ($urandom_range(0, 3) != 0);
      Trap_Clear = ($urandom_range(0, 7) == 0);
      op = ($urandom_range(0, 9) < 3) ? 5'($urandom_range(3, 4)) : 5'($urandom_range(0, 20));
      drive(1'($urandom_range(0, 3) != 0), op,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      step(1'b1);
    end

    // Issue_Count wraps after 2^16 issues
    Reset = 1'b1; Out_Ready = 1'b1; Trap_Clear = 1'b0;
    drive(1'b0, 5'd17, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1);
    Reset = 1'b0;
    drive(1'b1, 5'd17, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    repeat (65535) step(1'b0);
    chk("cnt_max", 32'(Issue_Count), 32'd65535);
    step(1'b1);
    chk("cnt_wrap", 32'(Issue_Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the ALU. Accepts one decoded instruction per cycle over a valid/ready handshake.
- Selects register or immediate for the second operand and forwards the ALU's previous result on read-after-write hazards.
- Traps divide/modulo by zero. Holds the selected operands and opcode in a registered output stage that drives the ALU's Input_1, Input_2 and ALU_Op.
- Output register updates on posedge Fast_Clock; the ALU evaluates on the following negedge.

Parameters:
- WIDTH, 32, datapath width of operands and forwarded result
- CNT_WIDTH, 16, width of Issue_Count

Ports:
- Fast_Clock  input  1  system clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- In_Valid  input  1  upstream instruction valid
- In_Ready  output  1  stage can accept an instruction this cycle
- In_Op  input  5  ALU opcode (0 ADD … 16 LT, 17 NOP, 18 IMM)
- In_Rs_Addr  input  5  first source register index
- In_Rt_Addr  input  5  second source register index
- In_Rs_Data  input  WIDTH  register-file value of Rs
- In_Rt_Data  input  WIDTH  register-file value of Rt
- In_Imm  input  WIDTH  sign-extended immediate
- In_Use_Imm  input  1  second operand comes from In_Imm instead of Rt
- In_Rd_Addr  input  5  destination register index
- In_Write_En  input  1  instruction writes Rd
- ALU_Result  input  WIDTH  ALU Result, fed back for forwarding
- Out_Ready  input  1  downstream accepts the current output
- Out_Valid  output  1  output register holds a live instruction
- Input_1  output  WIDTH  ALU first operand
- Input_2  output  WIDTH  ALU second operand
- ALU_Op  output  5  ALU opcode
- Out_Rd_Addr  output  5  destination of issued instruction
- Out_Write_En  output  1  issued instruction writes Rd
- Div_Zero  output  1  sticky divide-by-zero trap flag
- Trap_Clear  input  1  pulse to leave the trap state
- Issue_Count  output  CNT_WIDTH  count of issued instructions

Behaviour:
- Reset (sync, active-high): takes priority over all other inputs and aborts any in-flight instruction.
  - Out_Valid=0, Input_1=0, Input_2=0, ALU_Op=17, Out_Rd_Addr=0, Out_Write_En=0, Div_Zero=0, Issue_Count=0, FSM=RUN.
- FSM states RUN and TRAP.
  - In RUN: In_Ready = !Out_Valid || Out_Ready.
  - In TRAP: In_Ready = 0.
- Transfer occurs when In_Valid && In_Ready at posedge. On transfer:
  - Output register loads the new instruction.
  - Out_Valid=1.
  - Issue_Count increments, wrapping at 2^CNT_WIDTH to 0.
- No transfer but Out_Ready=1: Out_Valid=0, ALU_Op=17, Out_Write_En=0. Operand registers keep their values.
- No transfer and Out_Ready=0: all outputs hold; the ALU recomputes the same result.
- Forwarding condition per source: Out_Valid=1, Out_Write_En=1, Out_Rd_Addr!=0, and Out_Rd_Addr equals the source address.
  - Rs match: Input_1 = ALU_Result.
  - Rt match with In_Use_Imm=0: Input_2 = ALU_Result.
  - Forwarding is evaluated on the posedge of transfer. ALU_Result then reflects the producer currently in the output register.
  - A producer followed by a bubble is not forwarded; the register-file data is authoritative.
  - Register 0 is never forwarded.
- In_Use_Imm=1: Input_2 = In_Imm and Rt forwarding is ignored. Op 18 is issued unchanged; the ALU passes Input_2.
- Divide trap: op 3 or 4 whose final Input_2 (after immediate select and forwarding) is 0.
  - Issues ALU_Op=17 with Out_Write_En=0 and Out_Valid=1.
  - Sets Div_Zero=1 and moves to TRAP.
  - Issue_Count still increments.
- TRAP: no transfers occur. Trap_Clear=1 clears Div_Zero and returns to RUN the next cycle. Trap_Clear in RUN is ignored.
- Opcodes above 18 are passed through unchanged; the ALU defaults them to 0.
- Latency: one cycle from transfer to operands on the ALU inputs. The ALU result is valid half a cycle later, at negedge.
- Throughput: one instruction per cycle with no stalls.

Test Plan:
- Reset mid-stall with Out_Valid=1, Out_Ready=0 → next cycle Out_Valid=0, ALU_Op=17, Issue_Count=0, In_Ready=1.
- Back-to-back ADD r1=r2+r3 (5+7), then SUB r4=r1-r2 with stale In_Rs_Data=0 → second issue has Input_1=12 (forwarded), Input_2=5, ALU_Op=1.
- ADD with Rd=r0, Write_En=1, followed by a reader of r0 carrying In_Rs_Data=0 → no forwarding, Input_1=0.
- Out_Ready=0 for 3 cycles with In_Valid=1 → In_Ready=0 and outputs stable. Release → instruction transfers next cycle; Issue_Count increments by 1.
- DIV with In_Use_Imm=1, In_Imm=0 → ALU_Op=17, Out_Write_En=0, Div_Zero=1, In_Ready=0 until a Trap_Clear pulse, then RUN resumes.
- Issue_Count preset to 65535 by issuing 65535 instructions, then one more → Issue_Count=0.
